// File: rtl/audio_sample_scheduler.sv
// Frame-rate sample scheduler between the FIR output and the DAC serializer.
// Buffers FIR samples, selects FIR / test tone / mute, and updates dac_data once per LRCK frame.
module audio_sample_scheduler #(
   parameter int                          SAMPLE_W    = 16,
   parameter int                          FIFO_DEPTH  = 8,
   parameter int                          PRIME_LEVEL = 4,
   parameter int                          TONE_HALF   = 24,
   parameter logic signed [SAMPLE_W-1:0]  TONE_AMP    = 16'sh2000
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           fir_valid,
   input  logic signed [SAMPLE_W-1:0]     fir_sample,
   output logic                           fir_ready,
   input  logic [1:0]                     src_sel,
   input  logic                           AUD_DACLRCK,
   output logic [2*SAMPLE_W-1:0]          dac_data,
   output logic [1:0]                     state_out,
   output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
   output logic [15:0]                    underflow_cnt
);

   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int LW  = AW + 1;
   localparam int TCW = $clog2(TONE_HALF + 1);

   typedef enum logic [1:0] {
      S_MUTE     = 2'd0,
      S_PRIME    = 2'd1,
      S_RUN_FIR  = 2'd2,
      S_RUN_TONE = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      DS_ZERO = 2'd0,
      DS_FIFO = 2'd1,
      DS_TONE = 2'd2
   } dac_sel_t;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   function automatic logic signed [SAMPLE_W-1:0] tone_sample(input logic ph);
      return ph ? -TONE_AMP : TONE_AMP;
   endfunction

   // LRCK synchronizer (p0, p1) and edge-detect flop (p2)
   logic lrck_p0, lrck_p1, lrck_p2;
   logic frame_tick;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lrck_p0 <= 1'b0;
         lrck_p1 <= 1'b0;
         lrck_p2 <= 1'b0;
      end else begin
         lrck_p0 <= AUD_DACLRCK;
         lrck_p1 <= lrck_p0;
         lrck_p2 <= lrck_p1;
      end
   end

   assign frame_tick = lrck_p2 & ~lrck_p1;

   // Sample FIFO
   logic signed [SAMPLE_W-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]              wr_ptr, rd_ptr;
   logic [LW-1:0]              level;
   logic                       push, pop, flush;
   logic                       fifo_empty;
   logic signed [SAMPLE_W-1:0] pop_data;

   assign fir_ready  = (level != LW'(FIFO_DEPTH));
   assign push       = fir_valid & fir_ready;
   assign fifo_empty = (level == '0);
   assign pop_data   = mem[rd_ptr];
   assign fifo_level = level;

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= fir_sample;
   end

   // A flush keeps a sample pushed on the same cycle; only older contents are dropped.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (flush) begin
         rd_ptr <= wr_ptr;
         wr_ptr <= wr_ptr + AW'(push);
         level  <= LW'(push);
      end else begin
         wr_ptr <= wr_ptr + AW'(push);
         rd_ptr <= rd_ptr + AW'(pop);
         level  <= level + LW'(push) - LW'(pop);
      end
   end

   // Frame FSM: acts only on frame_tick
   state_t   state, state_nx;
   dac_sel_t dac_sel;
   logic     dac_ld, uf_inc, tone_rst, tone_adv;
   logic     src_fir, src_tone;

   assign src_fir  = (src_sel == 2'd0);
   assign src_tone = (src_sel == 2'd1);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state <= S_MUTE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      pop      = 1'b0;
      flush    = 1'b0;
      dac_ld   = 1'b0;
      dac_sel  = DS_ZERO;
      uf_inc   = 1'b0;
      tone_rst = 1'b0;
      tone_adv = 1'b0;
      if (frame_tick) begin
         unique case (state)
            S_MUTE: begin
               dac_ld = 1'b1;
               if (src_fir) begin
                  state_nx = S_PRIME;
               end else begin
                  flush = 1'b1;
                  if (src_tone) begin
                     state_nx = S_RUN_TONE;
                     tone_rst = 1'b1;
                  end
               end
            end
            S_PRIME: begin
               dac_ld = 1'b1;
               if (!src_fir) begin
                  state_nx = S_MUTE;
               end else if (level >= LW'(PRIME_LEVEL)) begin
                  state_nx = S_RUN_FIR;
                  pop      = 1'b1;
                  dac_sel  = DS_FIFO;
               end
            end
            S_RUN_FIR: begin
               if (src_fir) begin
                  if (fifo_empty) begin
                     uf_inc   = 1'b1;
                     state_nx = S_PRIME;
                  end else begin
                     pop     = 1'b1;
                     dac_ld  = 1'b1;
                     dac_sel = DS_FIFO;
                  end
               end else if (src_tone) begin
                  flush    = 1'b1;
                  dac_ld   = 1'b1;
                  dac_sel  = DS_TONE;
                  tone_adv = 1'b1;
                  state_nx = S_RUN_TONE;
               end else begin
                  dac_ld   = 1'b1;
                  state_nx = S_MUTE;
               end
            end
            S_RUN_TONE: begin
               dac_ld = 1'b1;
               if (src_tone) begin
                  dac_sel  = DS_TONE;
                  tone_adv = 1'b1;
               end else if (src_fir) begin
                  state_nx = S_PRIME;
               end else begin
                  state_nx = S_MUTE;
               end
            end
         endcase
      end
   end

   assign state_out = (state == S_RUN_TONE) ? 2'd2 : 2'(state);

   // Test-tone generator: phase flips every TONE_HALF emitted frames
   logic [TCW-1:0] tone_cnt;
   logic           tone_phase;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tone_cnt   <= '0;
         tone_phase <= 1'b0;
      end else if (tone_rst) begin
         tone_cnt   <= '0;
         tone_phase <= 1'b0;
      end else if (tone_adv) begin
         if (tone_cnt == TCW'(TONE_HALF - 1)) begin
            tone_cnt   <= '0;
            tone_phase <= ~tone_phase;
         end else begin
            tone_cnt <= tone_cnt + TCW'(1);
         end
      end
   end

   // Output word and underflow counter
   logic signed [SAMPLE_W-1:0] tone_val;
   assign tone_val = tone_sample(tone_phase);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dac_data <= '0;
      end else if (dac_ld) begin
         unique case (dac_sel)
            DS_FIFO: dac_data <= {pop_data, pop_data};
            DS_TONE: dac_data <= {tone_val, tone_val};
            default: dac_data <= '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         underflow_cnt <= '0;
      else if (uf_inc)
         underflow_cnt <= sat_inc16(underflow_cnt);
   end

endmodule

// File: tb/tb_audio_sample_scheduler.sv
// Directed bench for audio_sample_scheduler: priming, frame timing, underflow, full FIFO, tone, async reset.
module tb_audio_sample_scheduler;

   logic               clk = 1'b0;
   logic               rst;
   logic               fir_valid;
   logic signed [15:0] fir_sample;
   logic               fir_ready;
   logic [1:0]         src_sel;
   logic               lrck;
   logic [31:0]        dac_data;
   logic [1:0]         state_out;
   logic [3:0]         fifo_level;
   logic [15:0]        underflow_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   audio_sample_scheduler dut (
      .clk           (clk),
      .rst           (rst),
      .fir_valid     (fir_valid),
      .fir_sample    (fir_sample),
      .fir_ready     (fir_ready),
      .src_sel       (src_sel),
      .AUD_DACLRCK   (lrck),
      .dac_data      (dac_data),
      .state_out     (state_out),
      .fifo_level    (fifo_level),
      .underflow_cnt (underflow_cnt)
   );

   always #10 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [15:0] v);
      @(negedge clk);
      fir_valid  = 1'b1;
      fir_sample = v;
      @(negedge clk);
      fir_valid  = 1'b0;
   endtask

   task automatic frame();
      @(negedge clk);
      lrck = 1'b1;
      repeat (8) @(negedge clk);
      lrck = 1'b0;
      repeat (8) @(negedge clk);
   endtask

   initial begin
      rst        = 1'b0;
      fir_valid  = 1'b0;
      fir_sample = '0;
      src_sel    = 2'd0;
      lrck       = 1'b0;
      repeat (3) @(negedge clk);

      check("rst_dac",   dac_data, 32'h0);
      check("rst_state", 32'(state_out), 32'd0);
      check("rst_level", 32'(fifo_level), 32'd0);
      check("rst_uf",    32'(underflow_cnt), 32'd0);
      check("rst_ready", 32'(fir_ready), 32'd1);
      rst = 1'b1;

      // priming
      push(16'h0100);
      push(16'h0200);
      push(16'h0300);
      frame();
      frame();
      check("prime_state", 32'(state_out), 32'd1);
      check("prime_dac",   dac_data, 32'h0);
      check("prime_level", 32'(fifo_level), 32'd3);
      push(16'h0400);
      check("prime_level4", 32'(fifo_level), 32'd4);
      frame();
      check("run_dac",   dac_data, 32'h01000100);
      check("run_state", 32'(state_out), 32'd2);
      check("run_level", 32'(fifo_level), 32'd3);

      // stability during LRCK high and exact update cycle
      @(negedge clk);
      lrck = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (i == 3) begin
            fir_valid  = 1'b1;
            fir_sample = 16'h0500;
         end else begin
            fir_valid = 1'b0;
         end
         @(negedge clk);
         check("stable_high", dac_data, 32'h01000100);
      end
      lrck = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 check("tick_old", dac_data, 32'h01000100);
      @(posedge clk);
      #1 check("tick_new", dac_data, 32'h02000200);
      repeat (8) @(negedge clk);
      check("stable_level", 32'(fifo_level), 32'd3);
      frame();
      check("fifo_ord3", dac_data, 32'h03000300);
      frame();
      check("fifo_ord4", dac_data, 32'h04000400);
      frame();
      check("fifo_ord5", dac_data, 32'h05000500);
      check("drain_level", 32'(fifo_level), 32'd0);
      frame();
      check("uf_hold",  dac_data, 32'h05000500);
      check("uf_cnt",   32'(underflow_cnt), 32'd1);
      check("uf_state", 32'(state_out), 32'd1);

      // tone
      src_sel = 2'd3;
      frame();
      check("mute_state", 32'(state_out), 32'd0);
      check("mute_dac",   dac_data, 32'h0);
      src_sel = 2'd1;
      frame();
      check("tone_enter_state", 32'(state_out), 32'd2);
      check("tone_enter_dac",   dac_data, 32'h0);
      for (int i = 0; i < 24; i++) begin
         frame();
         check("tone_pos", dac_data, 32'h20002000);
      end
      for (int i = 0; i < 24; i++) begin
         frame();
         check("tone_neg", dac_data, 32'hE000E000);
      end
      frame();
      check("tone_wrap", dac_data, 32'h20002000);
      @(negedge clk);
      lrck = 1'b1;
      repeat (4) @(negedge clk);
      src_sel = 2'd3;
      repeat (4) @(negedge clk);
      check("midframe_hold", dac_data, 32'h20002000);
      lrck = 1'b0;
      repeat (8) @(negedge clk);
      check("midframe_dac",   dac_data, 32'h0);
      check("midframe_state", 32'(state_out), 32'd0);

      // full FIFO
      src_sel = 2'd0;
      frame();
      check("full_prime", 32'(state_out), 32'd1);
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         fir_valid  = 1'b1;
         fir_sample = (k < 8) ? 16'(16'h1000 + k) : 16'h7777;
      end
      @(negedge clk);
      check("full_level", 32'(fifo_level), 32'd8);
      check("full_ready", 32'(fir_ready), 32'd0);
      frame();
      check("full_pop_dac",  dac_data, 32'h10001000);
      check("full_refill",   32'(fifo_level), 32'd8);
      fir_valid = 1'b0;
      frame();
      check("full_pop2", dac_data, 32'h10011001);
      frame();
      frame();
      check("full_pop4",  dac_data, 32'h10031003);
      check("q5_level",   32'(fifo_level), 32'd5);

      // asynchronous reset mid-operation
      @(negedge clk);
      #3 rst = 1'b0;
      #1;
      check("arst_dac",   dac_data, 32'h0);
      check("arst_level", 32'(fifo_level), 32'd0);
      check("arst_uf",    32'(underflow_cnt), 32'd0);
      check("arst_state", 32'(state_out), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("restart_state", 32'(state_out), 32'd0);

      // underflow after priming with four samples
      push(16'h0100);
      push(16'h0200);
      push(16'h0300);
      push(16'h0400);
      frame();
      check("uf2_prime", 32'(state_out), 32'd1);
      frame();
      check("uf2_first", dac_data, 32'h01000100);
      frame();
      frame();
      frame();
      check("uf2_last", dac_data, 32'h04000400);
      frame();
      check("uf2_hold",  dac_data, 32'h04000400);
      check("uf2_cnt",   32'(underflow_cnt), 32'd1);
      check("uf2_state", 32'(state_out), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
